mips_data_mem: RTL and testbench
================================

# mips_data_mem

Parametrised data memory for the MIPS datapath, replacing the fixed 32-entry word memory. Supports byte/halfword/word loads and stores with sign or zero extension, a registered one-cycle read on the load/store port, a second read-only word port for debug and inspection, and misalignment detection. Sits in the MEM stage between the ALU address output and the write-back mux.

## Interface
- DEPTH, 256: number of 32-bit words; power of two, at least 4.
- ADDR_WIDTH, 32: byte-address width on both ports.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- memread  in  1  port A load request
- memwrite  in  1  port A store request
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- unsigned_ld  in  1  1 zero-extends byte/half loads; 0 sign-extends them
- addr  in  ADDR_WIDTH  port A byte address
- wdata  in  32  store data, right-aligned (byte in 7:0, half in 15:0)
- rdata  out  32  port A load data, extended
- rvalid  out  1  rdata/misalign valid, one-cycle pulse
- misalign  out  1  registered alignment fault for the access issued last cycle
- dirb  in  ADDR_WIDTH  port B byte address; bits 1:0 ignored
- rdata_b  out  32  port B word, registered

## Operation
- Word index = addr[log2(DEPTH)+1:2]. Higher address bits are ignored, so the address space wraps every 4*DEPTH bytes. Port B uses the same rule.
- Byte lanes are little-endian:
  - Byte at addr[1:0]=k occupies bits 8k+7:8k.
  - Half at addr[1]=h occupies bits 16h+15:16h.
- A store writes only the addressed lanes. Other lanes of the word are preserved.
- Misaligned accesses:
  - Definition: half with addr[0]=1, word with addr[1:0]≠0, or size=11.
  - Misaligned stores are suppressed (memory unchanged).
  - Misaligned loads return rdata=0.
  - Either case sets misalign=1 with rvalid=1 for one cycle. A misaligned pure store pulses rvalid too.
- Loads: the selected lane is shifted to bit 0 and extended according to unsigned_ld. Word loads ignore unsigned_ld.
- memread and memwrite may both be 1:
  - The store is performed.
  - The load reads the same address; the value returned is defined under Configuration.
- Port B reads every cycle unconditionally. If port B's word is written by port A in the same cycle, the Configuration rule applies.
- Memory contents are not cleared by reset; they are undefined until written.

## Timing
- Accesses are sampled on the rising clk edge.
- Load latency is 1 cycle: request at edge N gives rdata/rvalid/misalign valid after edge N and held through edge N+1.
- rvalid=1 exactly in the cycle following an edge that sampled memread=1 or a misaligned store. Otherwise rvalid=0, and rdata and misalign hold their last values.
- A store is visible to a load or a port B read sampled at the next edge.
- rdata_b updates every edge: word at dirb, 1-cycle latency.
- Reset (rst_n=0 at an edge):
  - Outputs: rdata=0, rvalid=0, misalign=0, rdata_b=0.
  - memread and memwrite are ignored; no store occurs.
- Reset mid-operation: a load issued in the same edge as reset is discarded. The first valid load can be issued at the first edge with rst_n=1.
- Back-to-back accesses are allowed every cycle with no stall.

## Configuration
- DMEM_BYPASS_EN defined: a read of a word written at the same edge returns the merged new word (write-first). This applies to port A load+store on the same word and to port B.
- Not defined: such a read returns the old word (read-first). Lane extraction and extension still apply to the old word.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then store word 0x00000036 at 20, then word load at 20 → next cycle rdata=0x00000036, rvalid=1, misalign=0.
- Store byte 0xF0 at 33 over word 0x11223344 at 32:
  - Signed byte load at 33 → 0xFFFFFFF0.
  - Unsigned byte load at 33 → 0x000000F0.
  - Word load at 32 → 0x1122F044.
- Store half 0x8001 at 34, then signed half load at 34 → 0xFFFF8001. Half load at 35 → misalign=1, rdata=0. Word store at 22 → misalign=1, and word 20 unchanged.
- Same-edge word store 0x4 at 8 with load at 8 and dirb=8 (word 8 previously 0x9):
  - With DMEM_BYPASS_EN: rdata=rdata_b=0x4.
  - Without: both 0x9.
- Wrap-around (DEPTH=256): store 0xAB at 1024, then word load at 0 → 0xAB.
- Issue load at 20 with rst_n=0 on the same edge → rvalid=0, rdata=0. Store with rst_n=0 → memory unchanged on a later read.

Source files
------------

// File: rtl/mips_data_mem.sv
// -----------------------------------------------------------------------------
// mips_data_mem
//
// Parametrised MEM-stage data memory for the MIPS datapath.
//   - Port A: byte/half/word loads and stores, little-endian lanes,
//     sign/zero extension, registered one-cycle load result.
//   - Port B: read-only word port for debug/inspection, registered, reads
//     every cycle.
//   - Misaligned accesses are flagged; misaligned stores are dropped and
//     misaligned loads return zero.
//
// Build option:
//   DMEM_BYPASS_EN  defined   -> same-edge read of a word being written
//                                returns the merged new word (write-first).
//                   undefined -> such a read returns the old word (read-first).
//
// Parameters:
//   DEPTH       number of 32-bit words (power of two, >= 4)
//   ADDR_WIDTH  byte-address width on both ports (>= log2(DEPTH)+2)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   memread      port A load request
//   memwrite     port A store request
//   size         00 byte, 01 half, 10 word, 11 reserved (always misaligned)
//   unsigned_ld  1 zero-extends byte/half loads, 0 sign-extends them
//   addr         port A byte address (wraps every 4*DEPTH bytes)
//   wdata        store data, right-aligned
//   rdata        port A load data, extended
//   rvalid       one-cycle pulse qualifying rdata/misalign
//   misalign     alignment fault for the access issued last cycle
//   dirb         port B byte address, bits 1:0 ignored
//   rdata_b      port B word, registered
// -----------------------------------------------------------------------------
module mips_data_mem #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memread,
  input  logic                  memwrite,
  input  logic [1:0]            size,
  input  logic                  unsigned_ld,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  rvalid,
  output logic                  misalign,
  input  logic [ADDR_WIDTH-1:0] dirb,
  output logic [31:0]           rdata_b
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Fault rule: half on odd byte, word off a word boundary, or reserved size.
  function automatic logic is_misaligned(input logic [1:0] sz,
                                         input logic [1:0] off);
    case (sz)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      SZ_WORD: is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  // Byte-lane enables for an aligned access.
  function automatic logic [3:0] lane_mask(input logic [1:0] sz,
                                           input logic [1:0] off);
    case (sz)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Replicating the right-aligned store data across the word puts the
  // correct bytes on every lane, so the mask alone selects the target lanes.
  function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                              input logic [31:0] wd,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  off);
    logic [31:0] lanes;
    logic [3:0]  mask;
    case (sz)
      SZ_BYTE: lanes = {4{wd[7:0]}};
      SZ_HALF: lanes = {2{wd[15:0]}};
      default: lanes = wd;
    endcase
    mask        = lane_mask(sz, off);
    merge_store = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merge_store[8*i +: 8] = lanes[8*i +: 8];
    end
  endfunction

  // Shift the addressed lane to bit 0 and extend; word loads pass through.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  off,
                                               input logic        uns);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext_s;
    b_s   = word[{off, 3'b000} +: 8];
    h_s   = off[1] ? word[31:16] : word[15:0];
    ext_s = 32'sd0;
    case (sz)
      SZ_BYTE: begin
        ext_s = b_s;
        if (uns) ext_s = {24'd0, b_s};
      end
      SZ_HALF: begin
        ext_s = h_s;
        if (uns) ext_s = {16'd0, h_s};
      end
      default: ext_s = word;
    endcase
    extract_load = ext_s;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: request decode and combinational array access
  // ---------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];

  logic [IDX_W-1:0] idx_a_p0;
  logic [IDX_W-1:0] idx_b_p0;
  logic [1:0]       off_p0;
  logic             mis_p0;
  logic             we_p0;
  logic             ld_evt_p0;
  logic [31:0]      old_a_p0;
  logic [31:0]      old_b_p0;
  logic [31:0]      new_a_p0;
  logic [31:0]      ld_word_p0;
  logic [31:0]      b_word_p0;
  logic [31:0]      ld_data_p0;

  // Address bits above the index and dirb[1:0] are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr, dirb};

  assign idx_a_p0 = addr[IDX_W+1:2];
  assign off_p0   = addr[1:0];
  assign idx_b_p0 = dirb[IDX_W+1:2];

  assign mis_p0    = is_misaligned(size, off_p0);
  // Reset blocks the store; a misaligned store is dropped.
  assign we_p0     = rst_n & memwrite & ~mis_p0;
  // A response is produced for any load, and for a faulting pure store.
  assign ld_evt_p0 = memread | (memwrite & mis_p0);

  assign old_a_p0 = mem[idx_a_p0];
  assign old_b_p0 = mem[idx_b_p0];
  assign new_a_p0 = merge_store(old_a_p0, wdata, size, off_p0);

`ifdef DMEM_BYPASS_EN
  // Write-first: a read of the word being stored this edge sees the merge.
  assign ld_word_p0 = we_p0 ? new_a_p0 : old_a_p0;
  assign b_word_p0  = (we_p0 && (idx_b_p0 == idx_a_p0)) ? new_a_p0 : old_b_p0;
`else
  // Read-first: same-edge reads return the pre-store contents.
  assign ld_word_p0 = old_a_p0;
  assign b_word_p0  = old_b_p0;
`endif

  assign ld_data_p0 = mis_p0 ? 32'd0
                             : extract_load(ld_word_p0, size, off_p0, unsigned_ld);

  // ---------------------------------------------------------------------------
  // Stage p1: array update and registered outputs
  // ---------------------------------------------------------------------------

  // Contents are not reset; they stay undefined until written.
  always_ff @(posedge clk) begin
    if (we_p0) mem[idx_a_p0] <= new_a_p0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata    <= 32'd0;
      rvalid   <= 1'b0;
      misalign <= 1'b0;
      rdata_b  <= 32'd0;
    end else begin
      rdata_b <= b_word_p0;
      rvalid  <= ld_evt_p0;
      // Without a response, rdata and misalign hold their last values.
      if (ld_evt_p0) begin
        rdata    <= ld_data_p0;
        misalign <= mis_p0;
      end
    end
  end

endmodule

// File: tb/tb_mips_data_mem.sv
// -----------------------------------------------------------------------------
// tb_mips_data_mem
//
// Directed testbench for mips_data_mem (DEPTH=256, ADDR_WIDTH=32). Each step
// drives one request, advances one clock edge, and checks the registered
// outputs 1 time unit after the edge against hand-computed values.
// -----------------------------------------------------------------------------
module tb_mips_data_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memread;
  logic        memwrite;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        misalign;
  logic [31:0] dirb;
  logic [31:0] rdata_b;

  int n_vec = 0;
  int n_err = 0;

`ifdef DMEM_BYPASS_EN
  localparam logic [31:0] SAME_EDGE = 32'h0000_0004;
`else
  localparam logic [31:0] SAME_EDGE = 32'h0000_0009;
`endif

  mips_data_mem #(.DEPTH(256), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memread    (memread),
    .memwrite   (memwrite),
    .size       (size),
    .unsigned_ld(unsigned_ld),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .misalign   (misalign),
    .dirb       (dirb),
    .rdata_b    (rdata_b)
  );

  always #5 clk = ~clk;

  // Drive one request and advance past the next rising edge.
  task automatic cyc(input logic r, input logic rd, input logic wr,
                     input logic [1:0] sz, input logic un,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] b);
    rst_n       = r;
    memread     = rd;
    memwrite    = wr;
    size        = sz;
    unsigned_ld = un;
    addr        = a;
    wdata       = wd;
    dirb        = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    cyc(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'd0);
    chk("rst_rdata",    rdata,    32'd0);
    chk("rst_rvalid",   rvalid,   32'd0);
    chk("rst_misalign", misalign, 32'd0);
    chk("rst_rdata_b",  rdata_b,  32'd0);

    // Word store then word load at 20
    cyc(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'd20, 32'h0000_0036, 32'd0);
    chk("store_no_rvalid", rvalid, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'd20, 32'd0, 32'd20);
    chk("ldw20_rdata",    rdata,    32'h0000_0036);
    chk("ldw20_rvalid",   rvalid,   32'd1);
    chk("ldw20_misalign", misalign, 32'd0);
    chk("portb_20",       rdata_b,  32'h0000_0036);
    idle();
    chk("idle_rvalid_low", rvalid, 32'd0);
    chk("idle_rdata_hold", rdata,  32'h0000_0036);

    // Byte store into word 32
    cyc(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'd32, 32'h1122_3344, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'd33, 32'h0000_00F0, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'd33, 32'd0, 32'd0);
    chk("ldb33_signed", rdata, 32'hFFFF_FFF0);
    cyc(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'd33, 32'd0, 32'd0);
    chk("ldbu33", rdata, 32'h0000_00F0);
    cyc(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'd32, 32'd0, 32'd0);
    chk("ldw32_after_byte", rdata, 32'h1122_F044);
    cyc(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'd35, 32'd0, 32'd0);
    chk("ldb35_signed_pos", rdata, 32'h0000_0011);

    // Half store at 34, half loads, misaligned accesses
    cyc(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'd34, 32'h0000_8001, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'd34, 32'd0, 32'd0);
    chk("ldh34_signed", rdata, 32'hFFFF_8001);
    cyc(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'd32, 32'd0, 32'd0);
    chk("ldhu32", rdata, 32'h0000_F044);
    cyc(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'd35, 32'd0, 32'd0);
    chk("ldh35_misalign", misalign, 32'd1);
    chk("ldh35_rdata",    rdata,    32'd0);
    chk("ldh35_rvalid",   rvalid,   32'd1);
    idle();
    chk("mis_hold_flag",  misalign, 32'd1);
    chk("mis_hold_rv",    rvalid,   32'd0);
    cyc(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'd22, 32'h0000_DEAD, 32'd0);
    chk("stw22_misalign", misalign, 32'd1);
    chk("stw22_rvalid",   rvalid,   32'd1);
    cyc(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'd20, 32'd0, 32'd0);
    chk("w20_unchanged",  rdata,    32'h0000_0036);
    chk("w20_misalign0",  misalign, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'd20, 32'd0, 32'd0);
    chk("size11_misalign", misalign, 32'd1);

    // Same-edge store+load and port B read of word 8
    cyc(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'd8, 32'h0000_0009, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'd8, 32'h0000_0004, 32'd8);
    chk("same_edge_rdata",   rdata,   SAME_EDGE);
    chk("same_edge_rdata_b", rdata_b, SAME_EDGE);
    cyc(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 32'd8);
    chk("next_edge_rdata",   rdata,   32'h0000_0004);
    chk("next_edge_rdata_b", rdata_b, 32'h0000_0004);

    // Wrap-around: 1024 aliases byte address 0
    cyc(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'd1024, 32'h0000_00AB, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'd1027);
    chk("wrap_rdata",   rdata,   32'h0000_00AB);
    chk("wrap_rdata_b", rdata_b, 32'h0000_00AB);

    // Reset on the same edge as a load, then as a store
    cyc(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'd20, 32'd0, 32'd20);
    chk("rst_load_rvalid",  rvalid,  32'd0);
    chk("rst_load_rdata",   rdata,   32'd0);
    chk("rst_load_rdata_b", rdata_b, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'd20, 32'h0000_0055, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'd20, 32'd0, 32'd0);
    chk("rst_store_blocked", rdata,  32'h0000_0036);
    chk("post_rst_rvalid",   rvalid, 32'd1);

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
